// File: rtl/urv_div_seq_pkg.sv
// Shared constants for the RV32M divide/remainder unit: funct3 codes and the
// writeback-mux source select for divider results.
package urv_div_seq_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  // Writeback mux select for the divider result
  localparam logic [2:0] RD_SOURCE_DIVIDE = 3'b011;

endpackage

// File: rtl/urv_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operates on magnitudes, fixes signs on the way out; one quotient bit per clock.
module urv_div_seq
  import urv_div_seq_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            x_kill_i,
  input  logic            x_start_i,
  input  logic [2:0]      x_fun_i,
  input  logic [XLEN-1:0] x_rs1_i,
  input  logic [XLEN-1:0] x_rs2_i,
  output logic            x_stall_req_o,
  output logic            x_busy_o,
  output logic            w_done_o,
  output logic [XLEN-1:0] w_result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_rem, r_quo, r_b;
  logic            r_q_neg, r_r_neg, r_want_rem;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  logic            w_signed, w_rem_op, w_start;
  logic [XLEN-1:0] w_a, w_b;
  logic [XLEN:0]   w_shift, w_trial;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_res;

  assign w_signed = (x_fun_i == FUNC_DIV) || (x_fun_i == FUNC_REM);
  assign w_rem_op = (x_fun_i == FUNC_REM) || (x_fun_i == FUNC_REMU);
  assign w_start  = x_start_i && !x_kill_i;
  assign w_a      = (w_signed && x_rs1_i[XLEN-1]) ? f_neg(x_rs1_i) : x_rs1_i;
  assign w_b      = (w_signed && x_rs2_i[XLEN-1]) ? f_neg(x_rs2_i) : x_rs2_i;

  // Partial remainder is always < 2^k before step k+1, so XLEN+1 bits never overflow
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_trial   = w_shift - {1'b0, r_b};
  assign w_rem_nxt = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
  assign w_res     = r_want_rem ? (r_r_neg ? f_neg(w_rem_nxt) : w_rem_nxt)
                                : (r_q_neg ? f_neg(w_quo_nxt) : w_quo_nxt);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_b        <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_want_rem <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      if (x_kill_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (x_start_i) begin
            r_state    <= S_ITER;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= w_a;
            r_b        <= w_b;
            r_want_rem <= w_rem_op;
            r_q_neg    <= w_signed && (x_rs1_i[XLEN-1] ^ x_rs2_i[XLEN-1]) && (x_rs2_i != '0);
            r_r_neg    <= w_signed && x_rs1_i[XLEN-1];
          end
          S_ITER: begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + 1'b1;
            if (r_count == CW'(XLEN-1)) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_res;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign x_stall_req_o = ((r_state == S_IDLE) && w_start) || (r_state == S_ITER);
  assign x_busy_o      = (r_state != S_IDLE);
  assign w_done_o      = r_done;
  assign w_result_o    = r_result;

endmodule

// File: tb/tb_urv_div_seq.sv
// Scoreboard bench for urv_div_seq: directed vectors plus a corner-biased
// random sweep against a behavioural reference.
module tb_urv_div_seq;
  import urv_div_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        x_kill_i = 1'b0;
  logic        x_start_i = 1'b0;
  logic [2:0]  x_fun_i = 3'b0;
  logic [31:0] x_rs1_i = '0;
  logic [31:0] x_rs2_i = '0;
  logic        x_stall_req_o, x_busy_o, w_done_o;
  logic [31:0] w_result_o;

  urv_div_seq #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .x_kill_i(x_kill_i), .x_start_i(x_start_i),
    .x_fun_i(x_fun_i), .x_rs1_i(x_rs1_i), .x_rs2_i(x_rs2_i),
    .x_stall_req_o(x_stall_req_o), .x_busy_o(x_busy_o),
    .w_done_o(w_done_o), .w_result_o(w_result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_n_i && w_done_o) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk($sformatf("result fun=%b a=%h b=%h", mon_e.fun, mon_e.a, mon_e.b),
            w_result_o, mon_e.exp);
      end
    end
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    logic ovf;
    sa = a; sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      FUNC_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
      FUNC_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
      FUNC_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit chk_stall);
    int cyc;
    bit seen, stall_ok;
    @(negedge clk_i);
    x_start_i = 1'b1; x_fun_i = fun; x_rs1_i = a; x_rs2_i = b;
    sb.push_back(sb_t'{fun, a, b, exp});
    #1 stall_ok = x_stall_req_o;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      x_start_i = 1'b0;
      if (w_done_o) begin
        seen = 1'b1;
        chk("latency", 32'(cyc), 32'd33);
        if (chk_stall) chk("stall_in_done", 32'(x_stall_req_o), 32'd0);
      end else if (!x_stall_req_o) stall_ok = 1'b0;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    if (chk_stall) chk("stall_cycles_0_32", 32'(stall_ok), 32'd1);
    @(negedge clk_i);
    chk("result_hold", w_result_o, exp);
    chk("done_single_pulse", 32'(w_done_o), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] pool [6];

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_result", w_result_o, 32'h0);
    chk("reset_done", 32'(w_done_o), 32'd0);
    chk("reset_busy", 32'(x_busy_o), 32'd0);
    chk("reset_stall", 32'(x_stall_req_o), 32'd0);
    rst_n_i = 1'b1;

    run_op(FUNC_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op(FUNC_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op(FUNC_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op(FUNC_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op(FUNC_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op(FUNC_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op(FUNC_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(FUNC_REM,  32'd5, 32'd0, 32'd5, 1'b0);
    run_op(FUNC_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(FUNC_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);
    run_op(FUNC_REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0);
    run_op(FUNC_DIVU, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(FUNC_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(FUNC_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_op(FUNC_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(FUNC_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0);

    // Kill in ITER cycle 10
    @(negedge clk_i);
    x_start_i = 1'b1; x_fun_i = FUNC_DIV; x_rs1_i = 32'd100; x_rs2_i = 32'd7;
    @(negedge clk_i);
    x_start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    chk("busy_before_kill", 32'(x_busy_o), 32'd1);
    x_kill_i = 1'b1;
    @(negedge clk_i);
    x_kill_i = 1'b0;
    chk("kill_busy", 32'(x_busy_o), 32'd0);
    chk("kill_stall", 32'(x_stall_req_o), 32'd0);
    repeat (40) @(negedge clk_i);
    run_op(FUNC_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Start and kill together
    @(negedge clk_i);
    x_start_i = 1'b1; x_kill_i = 1'b1; x_fun_i = FUNC_DIVU; x_rs1_i = 32'd50; x_rs2_i = 32'd5;
    #1 chk("startkill_stall", 32'(x_stall_req_o), 32'd0);
    @(negedge clk_i);
    chk("startkill_busy", 32'(x_busy_o), 32'd0);
    x_start_i = 1'b0; x_kill_i = 1'b0;
    repeat (40) @(negedge clk_i);

    // Asynchronous reset mid-ITER
    @(negedge clk_i);
    x_start_i = 1'b1; x_fun_i = FUNC_DIVU; x_rs1_i = 32'd100; x_rs2_i = 32'd7;
    @(negedge clk_i);
    x_start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_result", w_result_o, 32'h0);
    chk("async_rst_done", 32'(w_done_o), 32'd0);
    chk("async_rst_busy", 32'(x_busy_o), 32'd0);
    chk("async_rst_stall", 32'(x_stall_req_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (40) @(negedge clk_i);

    // Corner-biased random sweep
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h0000_0007;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      ra = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)]
         : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      rf = 3'b100 | 3'($urandom_range(0, 3));
      run_op(rf, ra, rb, ref_model(rf, ra, rb), 1'b0);
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk_i);
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
